// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling sequencer.
package rc4_pkg;
  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_WAIT, CALC, REQ, WAIT_SWAP, NEXT, DONE
  } ksa_state_t;

  localparam int SBOX_SIZE   = 256;
  localparam int KEY_LEN_DEF = 3;
  localparam int RD_LAT_DEF  = 1;
endpackage

// File: rtl/ksa_j_sequencer_if.sv
// S-box RAM read port plus the swap-stage handshake seen by the sequencer.
interface ksa_j_sequencer_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       swap_flag;
  logic [7:0] counter_i;
  logic [7:0] counter_j;
  logic       swap_done;

  modport master (
    output mem_addr, swap_flag, counter_i, counter_j,
    input  mem_rdata, swap_done
  );

  modport slave (
    input  mem_addr, swap_flag, counter_i, counter_j,
    output mem_rdata, swap_done
  );
endinterface

// File: rtl/key_byte_sel.sv
// Selects key byte k from the latched key; byte 0 is the most significant byte.
module key_byte_sel #(
  parameter int KEY_LEN = 3,
  parameter int KW      = 2
) (
  input  logic [8*KEY_LEN-1:0] i_key,
  input  logic [KW-1:0]        i_k,
  output logic [7:0]           o_byte
);
  always_comb begin
    o_byte = '0;
    for (int b = 0; b < KEY_LEN; b++) begin
      if (i_k == KW'(b)) o_byte = i_key[8*(KEY_LEN-1-b) +: 8];
    end
  end
endmodule

// File: rtl/ksa_j_sequencer.sv
// RC4 KSA j-sequencer: reads s[i], accumulates j, hands (i, j) to the swap stage
// and waits for its completion before moving to the next i.
module ksa_j_sequencer
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [8*KEY_LEN-1:0] i_secret_key,
  ksa_j_sequencer_if.master    if_seq,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int              KW        = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [7:0]      I_LAST    = 8'(SBOX_SIZE - 1);
  localparam logic [KW-1:0]   K_LAST    = KW'(KEY_LEN - 1);

  ksa_state_t r_state, w_state_nxt;

  logic [8*KEY_LEN-1:0] r_key;
  logic [7:0]           r_i, r_j, r_mem_addr, r_cnt_i, r_cnt_j;
  logic [KW-1:0]        r_k;
  logic [1:0]           r_wait;
  logic [7:0]           w_key_byte, w_j_nxt;
  logic                 w_swap_flag, w_done;

  key_byte_sel #(.KEY_LEN(KEY_LEN), .KW(KW)) u_key_sel (
    .i_key  (r_key),
    .i_k    (r_k),
    .o_byte (w_key_byte)
  );

  // 8-bit wrap is the mod-256 of the KSA
  assign w_j_nxt = r_j + if_seq.mem_rdata + w_key_byte;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_swap_flag = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE:      if (i_start) w_state_nxt = RD_ADDR;
      RD_ADDR:   w_state_nxt = RD_WAIT;
      RD_WAIT:   if (r_wait == WAIT_LAST) w_state_nxt = CALC;
      CALC:      w_state_nxt = REQ;
      REQ: begin
        w_swap_flag = 1'b1;
        w_state_nxt = WAIT_SWAP;
      end
      WAIT_SWAP: if (if_seq.swap_done) w_state_nxt = NEXT;
      NEXT:      w_state_nxt = (r_i == I_LAST) ? DONE : RD_ADDR;
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_key      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_wait     <= '0;
      r_mem_addr <= '0;
      r_cnt_i    <= '0;
      r_cnt_j    <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_key <= i_secret_key;
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
        end
        RD_ADDR: begin
          r_mem_addr <= r_i;
          r_wait     <= '0;
        end
        RD_WAIT: r_wait <= r_wait + 2'd1;
        // counters load here so they are already valid while swap_flag is high
        CALC: begin
          r_j     <= w_j_nxt;
          r_cnt_i <= r_i;
          r_cnt_j <= w_j_nxt;
        end
        NEXT: if (r_i != I_LAST) begin
          r_i <= r_i + 8'd1;
          r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign if_seq.mem_addr  = r_mem_addr;
  assign if_seq.swap_flag = w_swap_flag;
  assign if_seq.counter_i = r_cnt_i;
  assign if_seq.counter_j = r_cnt_j;
  assign o_busy           = (r_state != IDLE);
  assign o_done           = w_done;
endmodule

// File: tb/tb_ksa_j_sequencer.sv
// Bench: two sequencers (RD_LAT 1 and 3) with RAM and swap-stage models, checked
// against a software KSA reference.
module tb_ksa_j_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_a [2];
  logic [23:0] key_a   [2];
  logic        busy_a [2], done_a [2], flag_a [2], sd_r [2];
  logic [7:0]  ci_a [2], cj_a [2], addr_a [2];
  logic [7:0]  rd1 [2], rd2 [2], rd3 [2];
  logic [7:0]  mem [2][256];
  logic [7:0]  obs_i [2][512], obs_j [2][512];
  logic [7:0]  hi [2], hj [2];
  logic        pend [2];
  int          rem [2], spur_cnt [2];
  int          obs_cnt [2], done_cnt [2], obs_at_done [2], stab_err [2], dbl_err [2];
  bit          apply_sw [2];
  int          dly_fix [2], spur_at [2];
  bit          init_req = 1'b0;
  logic [7:0]  exp_j [256];
  int          n_checks = 0, n_fail = 0;

  ksa_j_sequencer_if bus0 ();
  ksa_j_sequencer_if bus1 ();

  ksa_j_sequencer #(.KEY_LEN(3), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start_a[0]), .i_secret_key(key_a[0]),
    .if_seq(bus0), .o_busy(busy_a[0]), .o_done(done_a[0]));

  ksa_j_sequencer #(.KEY_LEN(3), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start_a[1]), .i_secret_key(key_a[1]),
    .if_seq(bus1), .o_busy(busy_a[1]), .o_done(done_a[1]));

  assign bus0.mem_rdata = rd1[0];
  assign bus1.mem_rdata = rd3[1];
  assign bus0.swap_done = sd_r[0] | (spur_cnt[0] != 0);
  assign bus1.swap_done = sd_r[1] | (spur_cnt[1] != 0);
  assign flag_a[0] = bus0.swap_flag;  assign flag_a[1] = bus1.swap_flag;
  assign ci_a[0]   = bus0.counter_i;  assign ci_a[1]   = bus1.counter_i;
  assign cj_a[0]   = bus0.counter_j;  assign cj_a[1]   = bus1.counter_j;
  assign addr_a[0] = bus0.mem_addr;   assign addr_a[1] = bus1.mem_addr;

  // RAM with read pipeline and swap-stage model for both instances
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      sd_r[g] <= 1'b0;
      rd1[g] <= mem[g][addr_a[g]];
      rd2[g] <= rd1[g];
      rd3[g] <= rd2[g];
      if (spur_cnt[g] != 0) spur_cnt[g] <= spur_cnt[g] - 1;
      if (done_a[g]) begin
        done_cnt[g]    <= done_cnt[g] + 1;
        obs_at_done[g] <= obs_cnt[g];
      end
      if (reset) pend[g] <= 1'b0;
      else if (flag_a[g]) begin
        if (pend[g]) dbl_err[g] <= dbl_err[g] + 1;
        pend[g] <= 1'b1;
        hi[g] <= ci_a[g];
        hj[g] <= cj_a[g];
        rem[g] <= (dly_fix[g] >= 0) ? dly_fix[g] : int'($urandom_range(0, 7));
        if (obs_cnt[g] < 512) begin
          obs_i[g][obs_cnt[g]] <= ci_a[g];
          obs_j[g][obs_cnt[g]] <= cj_a[g];
        end
        obs_cnt[g] <= obs_cnt[g] + 1;
        if (apply_sw[g]) begin
          mem[g][ci_a[g]] <= mem[g][cj_a[g]];
          mem[g][cj_a[g]] <= mem[g][ci_a[g]];
        end
      end else if (pend[g]) begin
        if (ci_a[g] !== hi[g] || cj_a[g] !== hj[g]) stab_err[g] <= stab_err[g] + 1;
        if (rem[g] == 0) begin
          sd_r[g] <= 1'b1;
          pend[g] <= 1'b0;
          // stray swap_done over the following NEXT/RD_ADDR/RD_WAIT/CALC cycles
          if (int'(hi[g]) == spur_at[g]) spur_cnt[g] <= 5;
        end else rem[g] <= rem[g] - 1;
      end
      if (init_req) begin
        for (int x = 0; x < 256; x++) mem[g][x] <= 8'(x);
        obs_cnt[g] <= 0; done_cnt[g] <= 0; obs_at_done[g] <= 0;
        stab_err[g] <= 0; dbl_err[g] <= 0; spur_cnt[g] <= 0; pend[g] <= 1'b0;
      end
    end
  end

  // Software KSA over an identity S-box
  function automatic void model(input logic [23:0] k, input bit apply);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] j, t;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = j + s[i] + kb[i % 3];
      exp_j[i] = j;
      if (apply) begin t = s[i]; s[i] = s[j]; s[j] = t; end
    end
  endfunction

  task automatic init_env();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
  endtask

  task automatic kick(input int g, input logic [23:0] k);
    @(negedge clk); key_a[g] = k; start_a[g] = 1'b1;
    @(negedge clk); start_a[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done_cnt[g] != 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++; if (busy_a[g] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", g, busy_a[g]); end
      n_checks++; if (done_a[g] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d] got %b want 0", g, done_a[g]); end
      n_checks++; if (flag_a[g] !== 1'b0) begin n_fail++; $display("FAIL reset_flag[%0d] got %b want 0", g, flag_a[g]); end
      n_checks++; if ({ci_a[g], cj_a[g], addr_a[g]} !== 24'h0) begin
        n_fail++; $display("FAIL reset_regs[%0d] got i=%0d j=%0d a=%0d want 0", g, ci_a[g], cj_a[g], addr_a[g]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    int n; bit got;
    init_env(); apply_sw[0] = 1; dly_fix[0] = 0;
    @(negedge clk); key_a[0] = 24'($urandom); start_a[0] = 1'b1;
    n = 0; got = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); n++;
      @(negedge clk); start_a[0] = 1'b0;
      if (flag_a[0]) begin got = 1; break; end
    end
    n_checks++; if (!got || n != 4) begin n_fail++; $display("FAIL latency got %0d edges (seen=%0d) want 4", n, got); end
    wait_done(0, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL latency_done got timeout want done"); end
  endtask

  task automatic test_identity_zero_key();
    bit ok; int shown = 0;
    init_env(); apply_sw[0] = 0; dly_fix[0] = 0;
    kick(0, 24'h000000); wait_done(0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_done got timeout want done"); end
    n_checks++; if (obs_at_done[0] != 256) begin n_fail++; $display("FAIL t1_flags_at_done got %0d want 256", obs_at_done[0]); end
    n_checks++; if (done_cnt[0] != 1) begin n_fail++; $display("FAIL t1_done_width got %0d want 1", done_cnt[0]); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (obs_i[0][i] !== 8'(i) || obs_j[0][i] !== 8'((i * (i + 1) / 2) % 256)) begin
        n_fail++;
        if (shown++ < 8) $display("FAIL t1_seq[%0d] got (%0d,%0d) want (%0d,%0d)", i, obs_i[0][i], obs_j[0][i], i, (i*(i+1)/2)%256);
      end
    end
  endtask

  task automatic test_applied_swaps();
    bit ok; int shown = 0;
    init_env(); apply_sw[0] = 1; dly_fix[0] = 1;
    kick(0, 24'h010203); wait_done(0, ok); model(24'h010203, 1);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_done got timeout want done"); end
    n_checks++; if (obs_j[0][0] !== 8'd1 || obs_j[0][1] !== 8'd3) begin
      n_fail++; $display("FAIL t2_first got j0=%0d j1=%0d want 1,3", obs_j[0][0], obs_j[0][1]);
    end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (obs_i[0][i] !== 8'(i) || obs_j[0][i] !== exp_j[i]) begin
        n_fail++;
        if (shown++ < 8) $display("FAIL t2_seq[%0d] got (%0d,%0d) want (%0d,%0d)", i, obs_i[0][i], obs_j[0][i], i, exp_j[i]);
      end
    end
  endtask

  task automatic test_swap_delays();
    int dl [3] = '{0, 1, 7};
    bit ok; int bad; logic [23:0] k;
    foreach (dl[d]) begin
      init_env(); apply_sw[0] = 1; dly_fix[0] = dl[d];
      k = 24'($urandom); kick(0, k); wait_done(0, ok); model(k, 1);
      bad = 0;
      for (int i = 0; i < 256; i++) if (obs_i[0][i] !== 8'(i) || obs_j[0][i] !== exp_j[i]) bad++;
      n_checks++; if (!ok || bad != 0 || obs_cnt[0] != 256) begin
        n_fail++; $display("FAIL t3_seq dly=%0d got %0d bad, %0d swaps, done=%0d want 0 bad, 256 swaps", dl[d], bad, obs_cnt[0], ok);
      end
      n_checks++; if (stab_err[0] != 0 || dbl_err[0] != 0) begin
        n_fail++; $display("FAIL t3_hold dly=%0d got unstable=%0d early_flag=%0d want 0,0", dl[d], stab_err[0], dbl_err[0]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit ok, hit; int bad; logic [23:0] k;
    init_env(); apply_sw[0] = 1; dly_fix[0] = -1; spur_at[0] = 60;
    k = 24'($urandom); model(k, 1); hit = 0;
    fork
      begin kick(0, k); wait_done(0, ok); end
      begin
        for (int c = 0; c < 20000; c++) begin
          @(negedge clk);
          if (obs_cnt[0] > 50) begin hit = 1; break; end
        end
        key_a[0] = ~k; start_a[0] = 1'b1;
        @(negedge clk); start_a[0] = 1'b0;
      end
    join
    spur_at[0] = -1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (obs_i[0][i] !== 8'(i) || obs_j[0][i] !== exp_j[i]) bad++;
    n_checks++; if (!ok || !hit || bad != 0 || obs_cnt[0] != 256) begin
      n_fail++; $display("FAIL t4_seq got %0d bad, %0d swaps, done=%0d want 0 bad, 256 swaps", bad, obs_cnt[0], ok);
    end
    n_checks++; if (done_cnt[0] != 1 || busy_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL t4_end got done_cnt=%0d busy=%b want 1,0", done_cnt[0], busy_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, hit; int bad; logic [23:0] k;
    init_env(); apply_sw[0] = 1; dly_fix[0] = 7;
    kick(0, 24'($urandom)); hit = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (obs_cnt[0] >= 101) begin hit = 1; break; end
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (!hit || ci_a[0] !== 8'd0 || cj_a[0] !== 8'd0 || addr_a[0] !== 8'd0) begin
      n_fail++; $display("FAIL t5_regs got i=%0d j=%0d a=%0d (hit=%0d) want 0", ci_a[0], cj_a[0], addr_a[0], hit);
    end
    n_checks++; if (busy_a[0] !== 1'b0 || flag_a[0] !== 1'b0 || done_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL t5_ctl got busy=%b flag=%b done=%b want 0", busy_a[0], flag_a[0], done_a[0]);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL t5_idle got busy=%b want 0", busy_a[0]); end
    init_env(); dly_fix[0] = 1;
    k = 24'($urandom); kick(0, k); wait_done(0, ok); model(k, 1);
    n_checks++; if (obs_i[0][0] !== 8'd0 || obs_j[0][0] !== k[23:16]) begin
      n_fail++; $display("FAIL t5_restart got (%0d,%0d) want (0,%0d)", obs_i[0][0], obs_j[0][0], k[23:16]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (obs_i[0][i] !== 8'(i) || obs_j[0][i] !== exp_j[i]) bad++;
    n_checks++; if (!ok || bad != 0 || obs_cnt[0] != 256) begin
      n_fail++; $display("FAIL t5_seq got %0d bad, %0d swaps, done=%0d want 0 bad, 256 swaps", bad, obs_cnt[0], ok);
    end
  endtask

  task automatic test_rdlat3();
    bit ok; int shown = 0;
    init_env(); apply_sw[1] = 1; dly_fix[1] = -1;
    kick(1, 24'hAABBCC); wait_done(1, ok); model(24'hAABBCC, 1);
    n_checks++; if (!ok || obs_cnt[1] != 256) begin
      n_fail++; $display("FAIL t6_count got %0d swaps done=%0d want 256", obs_cnt[1], ok);
    end
    n_checks++; if (done_cnt[1] != 1) begin n_fail++; $display("FAIL t6_done_width got %0d want 1", done_cnt[1]); end
    n_checks++; if (stab_err[1] != 0 || dbl_err[1] != 0) begin
      n_fail++; $display("FAIL t6_hold got unstable=%0d early_flag=%0d want 0,0", stab_err[1], dbl_err[1]);
    end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (obs_i[1][i] !== 8'(i) || obs_j[1][i] !== exp_j[i]) begin
        n_fail++;
        if (shown++ < 8) $display("FAIL t6_seq[%0d] got (%0d,%0d) want (%0d,%0d)", i, obs_i[1][i], obs_j[1][i], i, exp_j[i]);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start_a[g] = 1'b0; key_a[g] = '0; apply_sw[g] = 1'b1; dly_fix[g] = 0; spur_at[g] = -1;
    end
    test_reset();
    test_latency();
    test_identity_zero_key();
    test_applied_swaps();
    test_swap_delays();
    test_busy_ignore();
    test_reset_mid();
    test_rdlat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
